// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types and constants for the sprite ROM arbiter: requester
// numbering, the requester id type and the return-pipeline entry.
package sprite_arb_pkg;

  localparam int NUM_REQ = 8;

  localparam int REQ_PLAYER = 0;
  localparam int REQ_ATTACK = 1;
  localparam int REQ_EATTACK = 2;
  localparam int REQ_ENEMY0 = 3;
  localparam int REQ_ENEMY1 = 4;
  localparam int REQ_ENEMY2 = 5;
  localparam int REQ_ENEMY3 = 6;
  localparam int REQ_HUD = 7;

  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

  // One slot of the return pipeline: who owns the data coming back.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } ret_entry_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Request/return bus between the sprite units plus the sprite ROM on one
// side and the arbiter on the other. The arbiter uses the slave modport.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 5
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             rvalid;
  logic [DATA_W-1:0]              rdata;
  logic                           rom_rd;
  logic [ADDR_W-1:0]              rom_addr;
  logic [DATA_W-1:0]              rom_data;

  modport slave (
    input  req, req_addr, rom_data,
    output gnt, rvalid, rdata, rom_rd, rom_addr
  );

  modport master (
    output req, req_addr, rom_data,
    input  gnt, rvalid, rdata, rom_rd, rom_addr
  );
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin winner search: first set bit of i_req at or above i_ptr,
// wrapping from NUM_REQ-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int NUM_REQ = 8,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_found,
  output logic [ID_W-1:0]    o_id
);

  // Walk the requesters in priority order starting at the pointer.
  always_comb begin
    logic [ID_W:0] w_sum;
    o_found = 1'b0;
    o_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(i);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end else begin
        w_sum = w_sum;
      end
      if (!o_found && i_req[w_sum[ID_W-1:0]]) begin
        o_found = 1'b1;
        o_id    = w_sum[ID_W-1:0];
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing the sprite ROM read port between the sprite
// units. Grants are combinational from the registered pointer and the
// request vector; returned data is steered back through a ROM_LAT-deep
// pipeline of owner ids. Optional frame stall counter is enabled by
// defining SPRITE_ARB_STALL_CNT_EN.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = sprite_arb_pkg::NUM_REQ,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 5,
  parameter int ROM_LAT = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
`ifdef SPRITE_ARB_STALL_CNT_EN
  output logic [15:0]          stall_cnt,
`endif
  sprite_rom_arbiter_if.slave  bus
);
  import sprite_arb_pkg::*;

  req_id_t            r_ptr;
  logic [NUM_REQ-1:0] r_inflight;
  ret_entry_t         r_pipe [ROM_LAT];

  logic [NUM_REQ-1:0] w_req_masked;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_rvalid;
  logic               w_found;
  logic               w_grant_en;
  req_id_t            w_win;
  req_id_t            w_ptr_inc;
  ret_entry_t         w_ret;

  assign w_ret = r_pipe[ROM_LAT-1];

  // Data-valid decode from the pipeline tail; suppressed while in reset.
  always_comb begin
    w_rvalid = '0;
    if (Reset && w_ret.valid) begin
      w_rvalid[w_ret.id] = 1'b1;
    end else begin
      w_rvalid = '0;
    end
  end

  // A requester whose data returns this cycle may be granted again now.
  assign w_req_masked = bus.req & ~(r_inflight & ~w_rvalid);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req   (w_req_masked),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_id    (w_win)
  );

  assign w_grant_en = w_found & Reset;
  assign w_ptr_inc  = (w_win == req_id_t'(NUM_REQ-1)) ? '0 : w_win + req_id_t'(1);

  // Grant and ROM drive for the winner; all zero when idle or in reset.
  always_comb begin
    w_gnt        = '0;
    bus.rom_rd   = 1'b0;
    bus.rom_addr = '0;
    if (w_grant_en) begin
      w_gnt[w_win] = 1'b1;
      bus.rom_rd   = 1'b1;
      bus.rom_addr = bus.req_addr[w_win];
    end else begin
      w_gnt = '0;
    end
  end

  assign bus.gnt    = w_gnt;
  assign bus.rvalid = w_rvalid;
  assign bus.rdata  = (Reset && w_ret.valid) ? bus.rom_data : '0;

  // Round-robin pointer: frame start rewinds to requester 0.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_ptr <= '0;
    end else if (frame_start) begin
      r_ptr <= '0;
    end else if (w_grant_en) begin
      r_ptr <= w_ptr_inc;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // In-flight masks: set on grant, cleared on the matching data return.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= (r_inflight & ~w_rvalid) | w_gnt;
    end
  end

  // Return pipeline carrying the owner of each outstanding ROM read.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= '{valid: w_grant_en, id: w_win};
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

`ifdef SPRITE_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall   = Reset & (|(w_req_masked & ~w_gnt));
  assign stall_cnt = r_stall_cnt;

  // Saturating count of cycles where an eligible requester was left waiting.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_stall_cnt <= 16'h0000;
    end else if (frame_start) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a two-cycle model ROM.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 8;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 5;
  localparam int ROM_LAT = 2;

  logic Clk;
  logic Reset;
  logic frame_start;
`ifdef SPRITE_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks;
  int n_errors;

  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
`ifdef SPRITE_ARB_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .bus         (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return a[4:0] ^ a[9:5] ^ 5'h0A;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return ADDR_W'(i * 37 + 5);
  endfunction

  // Model ROM: data for an address read in cycle c is presented in cycle c+2.
  logic [DATA_W-1:0] rom_d1, rom_d2;
  always @(posedge Clk) begin
    rom_d1 <= bus.rom_rd ? rom_f(bus.rom_addr) : 5'h00;
    rom_d2 <= rom_d1;
  end
  assign bus.rom_data = rom_d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [NUM_REQ-1:0] r, input logic fs);
    bus.req     = r;
    frame_start = fs;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'h0);
    chk({tag, "_rom_rd"}, 32'(bus.rom_rd), 32'h0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'h0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'h0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'h0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    Reset       = 1'b0;
    frame_start = 1'b0;
    bus.req     = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i] = addr_of(i);

    // Reset held for three edges with every requester asking.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(8'hFF, 1'b0);
      chk_idle("reset");
    end

    // Release: requester 0 first, then strict rotation 0..7,0,1.
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      Reset = 1'b1;
      drive(8'hFF, 1'b0);
      chk($sformatf("rr_gnt_%0d", k), 32'(bus.gnt), 32'(8'h01 << (k % 8)));
      chk($sformatf("rr_addr_%0d", k), 32'(bus.rom_addr), 32'(addr_of(k % 8)));
      if (k >= 2) begin
        chk($sformatf("rr_rvalid_%0d", k), 32'(bus.rvalid), 32'(8'h01 << ((k - 2) % 8)));
        chk($sformatf("rr_rdata_%0d", k), 32'(bus.rdata), 32'(rom_f(addr_of((k - 2) % 8))));
      end else begin
        chk($sformatf("rr_rvalid_%0d", k), 32'(bus.rvalid), 32'h0);
      end
    end

    // Drain the two outstanding fetches (requesters 0 and 1).
    next_cycle(); drive(8'h00, 1'b0);
    chk("drain_rvalid0", 32'(bus.rvalid), 32'h01);
    chk("drain_rdata0", 32'(bus.rdata), 32'(rom_f(addr_of(0))));
    next_cycle(); drive(8'h00, 1'b0);
    chk("drain_rvalid1", 32'(bus.rvalid), 32'h02);

    // Grant 5 so the pointer sits at 6, then check wrap 7 -> 0.
    next_cycle(); drive(8'h20, 1'b0);
    chk("wrap_setup_gnt", 32'(bus.gnt), 32'h20);
    next_cycle(); drive(8'h81, 1'b0);
    chk("wrap_gnt7", 32'(bus.gnt), 32'h80);
    next_cycle(); drive(8'h81, 1'b0);
    chk("wrap_gnt0", 32'(bus.gnt), 32'h01);
    chk("wrap_rvalid5", 32'(bus.rvalid), 32'h20);
    next_cycle(); drive(8'h00, 1'b0);
    chk("wrap_rvalid7", 32'(bus.rvalid), 32'h80);
    chk("wrap_rdata7", 32'(bus.rdata), 32'(rom_f(addr_of(7))));
    next_cycle(); drive(8'h00, 1'b0);
    chk("wrap_rvalid0", 32'(bus.rvalid), 32'h01);
    next_cycle(); drive(8'h00, 1'b0);
    chk_idle("idle");

    // Frame start coinciding with a grant to 4: grant proceeds, pointer -> 0.
    next_cycle(); drive(8'h10, 1'b1);
    chk("fs_gnt4", 32'(bus.gnt), 32'h10);
    next_cycle(); drive(8'h00, 1'b0);
    chk("fs_gap_gnt", 32'(bus.gnt), 32'h00);
    next_cycle(); drive(8'h30, 1'b0);
    chk("fs_rvalid4", 32'(bus.rvalid), 32'h10);
    chk("fs_next_gnt", 32'(bus.gnt), 32'h10);
    next_cycle(); drive(8'h00, 1'b0);
    next_cycle(); drive(8'h00, 1'b0);
    chk("fs_rvalid4b", 32'(bus.rvalid), 32'h10);

    // Reset one cycle after granting requester 2 discards that fetch.
    next_cycle(); drive(8'h04, 1'b0);
    chk("rst_mid_gnt2", 32'(bus.gnt), 32'h04);
    next_cycle(); Reset = 1'b0; drive(8'h00, 1'b0);
    chk("rst_mid_rvalid_a", 32'(bus.rvalid), 32'h00);
    next_cycle(); drive(8'h00, 1'b0);
    chk("rst_mid_rvalid_b", 32'(bus.rvalid), 32'h00);
    next_cycle(); Reset = 1'b1; drive(8'h04, 1'b0);
    chk("rst_mid_rvalid_c", 32'(bus.rvalid), 32'h00);
    chk("rst_unmask_gnt2", 32'(bus.gnt), 32'h04);
    next_cycle(); drive(8'h00, 1'b0);
    chk("rst_mid_rvalid_d", 32'(bus.rvalid), 32'h00);
    next_cycle(); drive(8'h00, 1'b0);
    chk("rst_new_rvalid2", 32'(bus.rvalid), 32'h04);
    chk("rst_new_rdata2", 32'(bus.rdata), 32'(rom_f(addr_of(2))));

    // Rewind pointer, then two requesters contend for ten cycles.
    next_cycle(); drive(8'h00, 1'b1);
    for (int k = 0; k < 10; k++) begin
      next_cycle(); drive(8'h03, 1'b0);
      chk($sformatf("pair_gnt_%0d", k), 32'(bus.gnt), (k % 2 == 0) ? 32'h01 : 32'h02);
`ifdef SPRITE_ARB_STALL_CNT_EN
      chk($sformatf("stall_cnt_%0d", k), 32'(stall_cnt), (k == 0) ? 32'h0 : 32'h1);
`endif
    end
    next_cycle(); drive(8'h00, 1'b1);
`ifdef SPRITE_ARB_STALL_CNT_EN
    chk("stall_cnt_hold", 32'(stall_cnt), 32'h1);
`endif
    next_cycle(); drive(8'h00, 1'b0);
`ifdef SPRITE_ARB_STALL_CNT_EN
    chk("stall_cnt_clear", 32'(stall_cnt), 32'h0);
`endif
    chk("final_gnt", 32'(bus.gnt), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
